// File: rtl/nibble_serial_alu_adder_pkg.sv
// Shared ALU definitions: default datapath width, FSM state encodings, op select.
// Latency: n/a (constants only).  Backpressure: n/a.
package alu_defs;
    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_serial_alu_adder_cla4bit.sv
// 4-bit carry-lookahead adder, purely combinational.
// Latency: 0 cycles.  Backpressure: none.
module cla4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[3:0];
    assign cout = w_c[4];
endmodule

// File: rtl/nibble_serial_alu_adder.sv
// Nibble-serial WIDTH-bit add/subtract reusing one cla4bit, with C/V/Z flags.
// Latency: out_valid WIDTH/4 cycles after accept; initiation interval WIDTH/4+2.
// Backpressure: out_ready low holds result/flags in DONE; in_ready low outside IDLE.
module nibble_serial_alu_adder
    import alu_defs::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_msb_a;
    logic             r_msb_b;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [3:0]       w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == IW'(NIB - 1));

    cla4bit u_cla (
        .a    (r_opa[4*r_idx +: 4]),
        .b    (r_opb[4*r_idx +: 4]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Result with the current nibble merged in; flags on the final pass see the full word.
    always_comb begin
        w_res_nxt = r_result;
        w_res_nxt[4*r_idx +: 4] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_msb_a  <= 1'b0;
            r_msb_b  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            // Subtract as A + ~B with the +1 entering as the first carry-in.
            r_opa   <= a;
            r_opb   <= (sub == OP_SUB) ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_msb_a <= a[WIDTH-1];
            r_msb_b <= (sub == OP_SUB) ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_result <= w_res_nxt;
            r_carry  <= w_cout;
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= (r_msb_a == r_msb_b) && (w_res_nxt[WIDTH-1] != r_msb_a);
                r_zero <= (w_res_nxt == '0);
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;
endmodule
